// File: rtl/xcel_read_arbiter_pkg.sv
// Shared state encoding and AXI constant codes for the conv3D read-channel arbiter.
package xcel_read_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/xcel_read_arbiter_rr_arbiter_comb.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr, wrapping.
module rr_arbiter_comb #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [2*NUM_REQ-1:0] rotated;
    logic [IDX_W:0]       sum;

    assign doubled = {req_valid, req_valid};
    assign rotated = doubled >> rr_ptr;

    // Rotating a doubled copy turns the wrap-around search into a plain lowest-bit scan.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
                if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                    sum = sum - (IDX_W + 1)'(NUM_REQ);
                end
                grant_valid = 1'b1;
                grant_idx   = sum[IDX_W-1:0];
            end
        end
        if (grant_valid) begin
            grant = NUM_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/xcel_read_arbiter.sv
// Round-robin arbiter sharing one simplified AXI read channel among the IFM, WT and OFM
// readers; one burst outstanding, beats steered back to the owner.
module xcel_read_arbiter #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32,
    parameter int NUM_REQ    = 3,
    parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*AXI_AWIDTH-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]      req_len,
    output logic [AXI_DWIDTH-1:0]      rsp_data,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic                       xcel_read_request_valid,
    input  logic                       xcel_read_request_ready,
    output logic [AXI_AWIDTH-1:0]      xcel_read_addr,
    output logic [31:0]                xcel_read_len,
    output logic [2:0]                 xcel_read_size,
    output logic [1:0]                 xcel_read_burst,
    input  logic [AXI_DWIDTH-1:0]      xcel_read_data,
    input  logic                       xcel_read_data_valid,
    output logic                       xcel_read_data_ready,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_id
);

    import xcel_read_arbiter_pkg::*;

    arb_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [31:0]           beat_cnt;
    logic [AXI_AWIDTH-1:0] addr_q;
    logic [31:0]           len_q;

    logic [NUM_REQ-1:0]    win_onehot;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_valid;
    logic                  owner_ready;
    logic                  beat_fire;
    logic [IDX_W-1:0]      next_ptr;

    rr_arbiter_comb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant       (win_onehot),
        .grant_idx   (win_idx),
        .grant_valid (win_valid)
    );

    assign owner_ready = rsp_ready[grant_id];
    assign beat_fire   = (state == DATA) && xcel_read_data_valid && owner_ready;
    assign next_ptr    = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

    // Everything handshake-related is gated by rst so the reset cycle itself shows idle outputs.
    assign req_ready               = (rst && state == IDLE) ? win_onehot : '0;
    assign xcel_read_request_valid = rst && (state == REQ);
    assign xcel_read_data_ready    = rst && (state == DATA) && owner_ready;
    assign rsp_valid               = (rst && state == DATA && xcel_read_data_valid)
                                     ? (NUM_REQ'(1) << grant_id) : '0;
    assign busy                    = rst && (state != IDLE);

    assign rsp_data        = xcel_read_data;
    assign xcel_read_addr  = addr_q;
    assign xcel_read_len   = len_q;
    assign xcel_read_size  = AXI_SIZE_4B;
    assign xcel_read_burst = AXI_BURST_INCR;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_valid) begin
                        addr_q   <= req_addr[win_idx*AXI_AWIDTH +: AXI_AWIDTH];
                        len_q    <= req_len[win_idx*32 +: 32];
                        grant_id <= win_idx;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (xcel_read_request_ready) begin
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    // len_q is beats minus one, so the fire that sees beat_cnt == len_q is the last.
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 32'd1;
                        if (beat_cnt == len_q) begin
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xcel_read_arbiter.sv
// Self-checking bench for xcel_read_arbiter: directed scenarios plus randomized bursts checked
// against a transaction-level round-robin model.
module tb_xcel_read_arbiter;

    localparam int NUM_REQ = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_len;
    logic [DW-1:0]         rsp_data;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic                  xcel_read_request_valid;
    logic                  xcel_read_request_ready;
    logic [AW-1:0]         xcel_read_addr;
    logic [31:0]           xcel_read_len;
    logic [2:0]            xcel_read_size;
    logic [1:0]            xcel_read_burst;
    logic [DW-1:0]         xcel_read_data;
    logic                  xcel_read_data_valid;
    logic                  xcel_read_data_ready;
    logic                  busy;
    logic [1:0]            grant_id;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;
    int exp_ptr       = 0;

    xcel_read_arbiter #(
        .AXI_AWIDTH (AW),
        .AXI_DWIDTH (DW),
        .NUM_REQ    (NUM_REQ)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_addr                (req_addr),
        .req_len                 (req_len),
        .rsp_data                (rsp_data),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .xcel_read_request_valid (xcel_read_request_valid),
        .xcel_read_request_ready (xcel_read_request_ready),
        .xcel_read_addr          (xcel_read_addr),
        .xcel_read_len           (xcel_read_len),
        .xcel_read_size          (xcel_read_size),
        .xcel_read_burst         (xcel_read_burst),
        .xcel_read_data          (xcel_read_data),
        .xcel_read_data_valid    (xcel_read_data_valid),
        .xcel_read_data_ready    (xcel_read_data_ready),
        .busy                    (busy),
        .grant_id                (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Round-robin rule: first valid requester counting up from the pointer, wrapping.
    function automatic int modelWinner(input logic [NUM_REQ-1:0] mask, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        assert (observed === expected) begin
            checks_passed++;
        end else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ-1:0] ready,
                                 input logic rq_ready, input logic dvalid, input logic [DW-1:0] data);
        req_valid               = valid;
        rsp_ready               = ready;
        xcel_read_request_ready = rq_ready;
        xcel_read_data_valid    = dvalid;
        xcel_read_data          = data;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        checkOutput({tag, "_rq_valid"}, 64'(xcel_read_request_valid), 64'(0));
        checkOutput({tag, "_data_ready"}, 64'(xcel_read_data_ready), 64'(0));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    // One complete burst; starts in an IDLE cycle and returns in the cycle after the last beat.
    task automatic doBurst(input logic [NUM_REQ-1:0] mask, input int min_len, input int max_len,
                           input int stall, output int winner);
        logic [31:0]        a [NUM_REQ];
        logic [31:0]        l [NUM_REQ];
        int                 w;
        int                 delivered;
        int                 cyc;
        logic               dv;
        logic [NUM_REQ-1:0] rr;
        logic [DW-1:0]      base;
        for (int i = 0; i < NUM_REQ; i++) begin
            a[i] = $urandom & 32'hFFFF_FFFC;
            l[i] = 32'($urandom_range(max_len, min_len));
            req_addr[i*AW +: AW] = a[i];
            req_len[i*32 +: 32]  = l[i];
        end
        applyStimulus(mask, '1, 1'b1, 1'b1, $urandom);
        #1;
        w = modelWinner(mask, exp_ptr);
        winner = w;
        checkOutput("idle_busy", 64'(busy), 64'(0));
        checkOutput("grant_ready", 64'(req_ready), 64'(1 << w));
        checkOutput("idle_data_ready", 64'(xcel_read_data_ready), 64'(0));
        checkOutput("idle_rsp_valid", 64'(rsp_valid), 64'(0));
        stepCycle();
        req_valid            = mask & ~NUM_REQ'(1 << w);
        xcel_read_data_valid = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            xcel_read_request_ready = (s == stall);
            #1;
            checkOutput("rq_valid", 64'(xcel_read_request_valid), 64'(1));
            checkOutput("rq_addr", 64'(xcel_read_addr), 64'(a[w]));
            checkOutput("rq_len", 64'(xcel_read_len), 64'(l[w]));
            checkOutput("rq_req_ready", 64'(req_ready), 64'(0));
            checkOutput("rq_grant_id", 64'(grant_id), 64'(w));
            stepCycle();
        end
        xcel_read_request_ready = 1'b0;
        delivered = 0;
        cyc       = 0;
        base      = $urandom;
        while (delivered <= int'(l[w]) && cyc < 400) begin
            dv = ($urandom_range(3, 0) != 0);
            rr = NUM_REQ'($urandom_range(7, 0));
            xcel_read_data_valid = dv;
            rsp_ready            = rr;
            xcel_read_data       = base + DW'(delivered);
            #1;
            checkOutput("beat_rsp_valid", 64'(rsp_valid), dv ? 64'(1 << w) : 64'(0));
            checkOutput("beat_data_ready", 64'(xcel_read_data_ready), 64'(rr[w]));
            checkOutput("beat_busy", 64'(busy), 64'(1));
            checkOutput("beat_req_ready", 64'(req_ready), 64'(0));
            if (dv) checkOutput("beat_data", 64'(rsp_data), 64'(base + DW'(delivered)));
            if (dv && rr[w]) delivered++;
            stepCycle();
            cyc++;
        end
        checkOutput("beat_count", 64'(delivered), 64'(l[w] + 32'd1));
        exp_ptr = (w + 1) % NUM_REQ;
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int w;
        rst      = 1'b0;
        req_addr = '0;
        req_len  = '0;
        applyStimulus('1, '1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        stepCycle();
        #1;
        checkQuiet("reset");
        checkOutput("reset_grant_id", 64'(grant_id), 64'(0));
        checkOutput("reset_size", 64'(xcel_read_size), 64'(2));
        checkOutput("reset_burst", 64'(xcel_read_burst), 64'(1));
        checkOutput("reset_addr", 64'(xcel_read_addr), 64'(0));

        $display("[TB] directed single request on requester 1");
        @(negedge clk);
        rst = 1'b1;
        req_addr[1*AW +: AW] = 32'h0000_1000;
        req_len[1*32 +: 32]  = 32'd3;
        applyStimulus(3'b010, '0, 1'b0, 1'b0, '0);
        #1;
        checkOutput("single_req_ready", 64'(req_ready), 64'(3'b010));
        stepCycle();
        req_valid = '0;
        #1;
        checkOutput("single_rq_valid", 64'(xcel_read_request_valid), 64'(1));
        checkOutput("single_rq_addr", 64'(xcel_read_addr), 64'(32'h1000));
        checkOutput("single_rq_len", 64'(xcel_read_len), 64'(3));
        xcel_read_request_ready = 1'b1;
        stepCycle();
        xcel_read_request_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, 3'b010, 1'b0, 1'b1, 32'hA0 + 32'(i));
            #1;
            checkOutput("single_rsp_valid", 64'(rsp_valid), 64'(3'b010));
            checkOutput("single_rsp_data", 64'(rsp_data), 64'(32'hA0 + 32'(i)));
            stepCycle();
        end
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        #1;
        checkOutput("single_done_busy", 64'(busy), 64'(0));
        exp_ptr = 2;

        $display("[TB] pointer follow-up, stalled request, long burst with backpressure");
        @(negedge clk);
        doBurst(3'b101, 1, 3, 0, w);
        checkOutput("ptr_after_single", 64'(w), 64'(2));
        doBurst(3'b111, 2, 2, 5, w);
        doBurst(3'b100, 7, 7, 0, w);

        $display("[TB] round-robin order after reset");
        rst = 1'b0;
        stepCycle();
        rst = 1'b1;
        exp_ptr = 0;
        for (int k = 0; k < 4; k++) begin
            doBurst(3'b111, 0, 0, 0, w);
            checkOutput("rr_order", 64'(w), 64'(k % NUM_REQ));
        end

        $display("[TB] beats offered while idle");
        for (int i = 0; i < 3; i++) begin
            applyStimulus('0, '1, 1'b0, 1'b1, $urandom);
            #1;
            checkQuiet("idle_beat");
            stepCycle();
        end

        $display("[TB] reset in the middle of a burst");
        req_addr[1*AW +: AW] = 32'h0000_2000;
        req_len[1*32 +: 32]  = 32'd3;
        applyStimulus(3'b010, '0, 1'b0, 1'b0, '0);
        #1;
        checkOutput("mid_req_ready", 64'(req_ready), 64'(3'b010));
        stepCycle();
        applyStimulus('0, '0, 1'b1, 1'b0, '0);
        stepCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus('0, 3'b010, 1'b0, 1'b1, 32'(i));
            #1;
            checkOutput("mid_beat_valid", 64'(rsp_valid), 64'(3'b010));
            stepCycle();
        end
        rst = 1'b0;
        applyStimulus('0, '1, 1'b0, 1'b1, 32'h5555);
        #1;
        checkQuiet("mid_reset_cycle");
        stepCycle();
        rst = 1'b1;
        #1;
        checkQuiet("mid_after_reset");
        checkOutput("mid_grant_id", 64'(grant_id), 64'(0));
        checkOutput("mid_len_q", 64'(xcel_read_len), 64'(0));
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        exp_ptr = 0;
        doBurst(3'b101, 0, 2, 1, w);
        checkOutput("ptr_after_reset", 64'(w), 64'(0));

        $display("[TB] randomized bursts");
        for (int n = 0; n < 20; n++) begin
            logic [NUM_REQ-1:0] m;
            m = NUM_REQ'($urandom_range(7, 1));
            doBurst(m, 0, 5, $urandom_range(2, 0), w);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
